gf_linmap_pipe: RTL

- Parametrised, pipelined GF(2) 8x8 bit-matrix linear map applied in parallel to LANES bytes per transfer.
- Successor to the fixed composite-field-to-GF(2^8) reverse-isomorphism wire network. The matrix is runtime-reloadable, so one block serves forward/reverse isomorphism and other basis changes in the S-box datapath.
- Valid/ready streaming on both sides. Matrix update is a shadow-load, then a drained commit.

---
 rtl/gf_linmap_pipe.sv | 136 +++++++++++++
 1 files changed

// File: rtl/gf_linmap_pipe.sv
// Pipelined GF(2) 8x8 bit-matrix map over LANES bytes, runtime-reloadable via shadow load + drained commit.
// Define GF_LINMAP_AFFINE_EN to add a committed XOR constant (full affine map).
module gf_linmap_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_row,
  input  logic [7:0]           cfg_data,
  input  logic                 cfg_commit,
  output logic                 cfg_busy,
  output logic                 cfg_done
`ifdef GF_LINMAP_AFFINE_EN
  ,
  input  logic                 cfg_const_we,
  input  logic [7:0]           cfg_const
`endif
);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  // Row r is the input mask whose parity gives output bit r; index 7 is first in the concatenation.
  localparam logic [7:0][7:0] DEFAULT_ROWS = {8'hE2, 8'h44, 8'h62, 8'h76,
                                              8'h3E, 8'h9E, 8'h30, 8'h75};

  state_t                          r_state;
  logic                            r_busy;
  logic                            r_done;
  logic [7:0][7:0]                 r_active;
  logic [7:0][7:0]                 r_shadow;
  logic [STAGES-1:0]               r_valid;
  logic [STAGES-1:0][8*LANES-1:0]  r_data;

  logic                            w_advance;
  logic                            w_empty;
  logic [7:0]                      w_const;
  logic [8*LANES-1:0]              w_mapped;

  function automatic logic [7:0] lin_map(input logic [7:0] b, input logic [7:0][7:0] m);
    logic [7:0] y;
    for (int r = 0; r < 8; r++) y[r] = ^(b & m[r]);
    return y;
  endfunction

`ifdef GF_LINMAP_AFFINE_EN
  logic [7:0] r_const_active;
  logic [7:0] r_const_shadow;
  assign w_const = r_const_active;
`else
  assign w_const = 8'h00;
`endif

  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign cfg_busy  = r_busy;
  assign cfg_done  = r_done;

  // All stages move in lockstep, so bubbles are carried rather than squeezed out.
  assign w_advance = out_ready | ~out_valid;
  assign in_ready  = w_advance & (r_state == ST_RUN);
  assign w_empty   = ~|r_valid;

  // NOTE: w_mapped gets a full default before the loop so synthesis never infers a latch.
  always_comb begin
    w_mapped = '0;
    for (int l = 0; l < LANES; l++) begin
      w_mapped[8*l +: 8] = lin_map(in_data[8*l +: 8], r_active) ^ w_const;
    end
  end

  // NOTE: data registers are reset as well, because out_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else if (w_advance) begin
      r_valid[0] <= in_valid & in_ready;
      r_data[0]  <= w_mapped;
      for (int s = 1; s < STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_data[s]  <= r_data[s-1];
      end
    end
  end

  // NOTE: non-blocking updates let the swap read the pre-edge shadow, so a same-cycle
  // row write lands in shadow only and never leaks into the active matrix.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_active <= DEFAULT_ROWS;
      r_shadow <= DEFAULT_ROWS;
`ifdef GF_LINMAP_AFFINE_EN
      r_const_active <= 8'h00;
      r_const_shadow <= 8'h00;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (cfg_commit) begin
            r_state <= ST_DRAIN;
            r_busy  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_active <= r_shadow;
`ifdef GF_LINMAP_AFFINE_EN
            r_const_active <= r_const_shadow;
`endif
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
      if (cfg_we) r_shadow[cfg_row] <= cfg_data;
`ifdef GF_LINMAP_AFFINE_EN
      if (cfg_const_we) r_const_shadow <= cfg_const;
`endif
    end
  end

endmodule
